// File: rtl/parking_occupancy_counter_if.sv
// Handshake bundle between the entry/exit sequencer side and the occupancy counter.
// OCC_BCD_EN adds the decimal display outputs.
interface parking_occupancy_counter_if #(parameter int W = 5);
  logic         entrada;
  logic         salida;
  logic         load;
  logic [W-1:0] load_value;
  logic         err_clr;
  logic [W-1:0] count;
  logic         full;
  logic         empty;
  logic         cambio;
  logic         overflow_err;
  logic         underflow_err;
`ifdef OCC_BCD_EN
  logic [3:0]   bcd_dec;
  logic [3:0]   bcd_uni;
`endif

  modport master (
    output entrada, salida, load, load_value, err_clr,
    input  count, full, empty, cambio, overflow_err, underflow_err
`ifdef OCC_BCD_EN
    , input bcd_dec, bcd_uni
`endif
  );

  modport slave (
    input  entrada, salida, load, load_value, err_clr,
    output count, full, empty, cambio, overflow_err, underflow_err
`ifdef OCC_BCD_EN
    , output bcd_dec, bcd_uni
`endif
  );
endinterface

// File: rtl/parking_occupancy_counter.sv
// Parking lot occupancy counter: edge-detected entry/exit, saturating count, operator preset,
// sticky error flags. Define OCC_BCD_EN for registered tens/units outputs.
module parking_occupancy_counter #(
  parameter int CAPACIDAD = 20,
  parameter int W         = 5
) (
  input logic clk,
  input logic reset,
  parking_occupancy_counter_if.slave bus
);
  localparam logic [W-1:0] CAP_W = W'(CAPACIDAD);

  if (CAPACIDAD < 1 || CAPACIDAD > (2**W - 1)) begin : g_bad_cap
    $error("CAPACIDAD out of range for W");
  end
`ifdef OCC_BCD_EN
  if (CAPACIDAD > 99) begin : g_bad_bcd
    $error("CAPACIDAD must be <= 99 with BCD outputs");
  end
`endif

  logic [W-1:0] count_q, next_count, clamped;
  logic         ent_q, sal_q, ent_ev, sal_ev;
  logic         cambio_q, ovf_q, unf_q, ovf_set, unf_set;

  assign ent_ev  = bus.entrada & ~ent_q;
  assign sal_ev  = bus.salida  & ~sal_q;
  assign clamped = (bus.load_value > CAP_W) ? CAP_W : bus.load_value;

  // Load discards events; simultaneous entry+exit is a net-zero no-op even at the limits.
  always_comb begin
    next_count = count_q;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    if (bus.load) begin
      next_count = clamped;
    end else if (ent_ev && !sal_ev) begin
      if (count_q == CAP_W) ovf_set = 1'b1;
      else                  next_count = count_q + W'(1);
    end else if (sal_ev && !ent_ev) begin
      if (count_q == '0) unf_set = 1'b1;
      else               next_count = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      cambio_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      ent_q    <= 1'b0;
      sal_q    <= 1'b0;
    end else begin
      count_q  <= next_count;
      cambio_q <= (next_count != count_q);
      ovf_q    <= ovf_set | (ovf_q & ~bus.err_clr);
      unf_q    <= unf_set | (unf_q & ~bus.err_clr);
      ent_q    <= bus.entrada;
      sal_q    <= bus.salida;
    end
  end

  assign bus.count         = count_q;
  assign bus.full          = (count_q == CAP_W);
  assign bus.empty         = (count_q == '0);
  assign bus.cambio        = cambio_q;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;

`ifdef OCC_BCD_EN
  logic [3:0] dec_q, uni_q;

  // Derived from next_count so the digits land on the same edge as count.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_q <= '0;
      uni_q <= '0;
    end else begin
      dec_q <= 4'(next_count / W'(10));
      uni_q <= 4'(next_count % W'(10));
    end
  end

  assign bus.bcd_dec = dec_q;
  assign bus.bcd_uni = uni_q;
`endif
endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Directed vector table plus randomized run against an integer model of the lot.
module tb_parking_occupancy_counter;
  localparam int CAP = 20;
  localparam int W   = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  parking_occupancy_counter_if #(.W(W)) bus ();
  parking_occupancy_counter #(.CAPACIDAD(CAP), .W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit rst, ent, sal, ld, clr;
    int lv;
    int exp_count;
    bit exp_cambio, exp_ovf, exp_unf;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;

  task automatic add(input bit rst, ent, sal, ld, input int lv, input bit clr,
                     input int c, input bit cam, ovf, unf);
    vec_t v;
    v.rst = rst; v.ent = ent; v.sal = sal; v.ld = ld; v.lv = lv; v.clr = clr;
    v.exp_count = c; v.exp_cambio = cam; v.exp_ovf = ovf; v.exp_unf = unf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic drive(input bit rst, ent, sal, ld, input int lv, input bit clr);
    reset = rst; bus.entrada = ent; bus.salida = sal; bus.load = ld;
    bus.load_value = W'(lv); bus.err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int c, input bit cam, ovf, unf);
    chk({tag, " count"}, int'(bus.count), c);
    chk({tag, " full"}, int'(bus.full), int'(c == CAP));
    chk({tag, " empty"}, int'(bus.empty), int'(c == 0));
    chk({tag, " cambio"}, int'(bus.cambio), int'(cam));
    chk({tag, " overflow_err"}, int'(bus.overflow_err), int'(ovf));
    chk({tag, " underflow_err"}, int'(bus.underflow_err), int'(unf));
`ifdef OCC_BCD_EN
    chk({tag, " bcd_dec"}, int'(bus.bcd_dec), c / 10);
    chk({tag, " bcd_uni"}, int'(bus.bcd_uni), c % 10);
`endif
  endtask

  // Reference lot: plain integers, rising edges from previous input levels.
  int  m_occ, m_nxt;
  bit  m_pe, m_ps, m_ovf, m_unf, m_cam;

  task automatic model(input bit rst, ent, sal, ld, input int lv, input bit clr);
    bit ee, es, os, us;
    if (rst) begin
      m_occ = 0; m_cam = 0; m_ovf = 0; m_unf = 0; m_pe = 0; m_ps = 0;
      return;
    end
    ee = ent && !m_pe; es = sal && !m_ps; os = 0; us = 0;
    m_nxt = m_occ;
    if (ld)            m_nxt = (lv > CAP) ? CAP : lv;
    else if (ee && !es) begin if (m_occ == CAP) os = 1; else m_nxt = m_occ + 1; end
    else if (es && !ee) begin if (m_occ == 0) us = 1; else m_nxt = m_occ - 1; end
    m_cam = (m_nxt != m_occ);
    m_occ = m_nxt;
    m_ovf = os || (m_ovf && !clr);
    m_unf = us || (m_unf && !clr);
    m_pe = ent; m_ps = sal;
  endtask

  initial begin
    //   rst e s ld lv clr  cnt cam ovf unf
    add(1, 0,0,0, 0,0,   0,0,0,0);
    add(1, 0,0,0, 0,0,   0,0,0,0);
    add(0, 0,0,0, 0,0,   0,0,0,0);
    for (int r = 0; r < 3; r++) begin
      add(0, 1,0,0, 0,0, r+1,1,0,0);
      add(0, 1,0,0, 0,0, r+1,0,0,0);
      add(0, 1,0,0, 0,0, r+1,0,0,0);
      add(0, 0,0,0, 0,0, r+1,0,0,0);
    end
    add(0, 0,0,1,19,0,  19,1,0,0);
    add(0, 1,0,0, 0,0,  20,1,0,0);
    add(0, 0,0,0, 0,0,  20,0,0,0);
    add(0, 0,0,1,31,0,  20,0,0,0);   // clamp, no change
    add(0, 1,0,0, 0,0,  20,0,1,0);
    add(0, 0,0,0, 0,0,  20,0,1,0);
    add(0, 0,0,0, 0,1,  20,0,0,0);
    add(0, 1,1,0, 0,0,  20,0,0,0);   // both at full: no error
    add(0, 0,0,0, 0,0,  20,0,0,0);
    add(0, 1,0,0, 0,1,  20,0,1,0);   // set wins over clear
    add(0, 0,0,0, 0,1,  20,0,0,0);
    add(0, 0,0,1, 0,0,   0,1,0,0);
    add(0, 0,1,0, 0,0,   0,0,0,1);
    add(0, 0,0,0, 0,0,   0,0,0,1);
    add(0, 0,0,0, 0,1,   0,0,0,0);
    add(0, 1,1,0, 0,0,   0,0,0,0);   // both at empty: no error
    add(0, 0,0,1, 5,0,   5,1,0,0);
    add(0, 1,1,0, 0,0,   5,0,0,0);
    add(0, 0,0,1, 7,0,   7,1,0,0);
    add(0, 1,0,1, 2,0,   2,1,0,0);   // entry discarded by load
    add(0, 1,0,0, 0,0,   2,0,0,0);
    add(0, 1,0,0, 0,0,   2,0,0,0);
    add(1, 1,0,0, 0,0,   0,0,0,0);
    add(0, 1,0,0, 0,0,   1,1,0,0);   // held level counts once after reset
    add(0, 1,0,0, 0,0,   1,0,0,0);
    add(0, 0,1,0, 0,0,   0,1,0,0);
    add(0, 0,1,0, 0,0,   0,0,0,0);
    add(0, 0,0,0, 0,0,   0,0,0,0);
    add(0, 0,1,0, 0,0,   0,0,0,1);
    add(1, 0,0,0, 0,0,   0,0,0,0);   // reset clears sticky error

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ent, vecs[i].sal, vecs[i].ld, vecs[i].lv, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_cambio,
                vecs[i].exp_ovf, vecs[i].exp_unf);
    end

    model(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      bit rst, ent, sal, ld, clr;
      int lv;
      rst = ($urandom_range(0, 59) == 0);
      ld  = ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 11) == 0);
      ent = ($urandom_range(0, 2) == 0);
      sal = ($urandom_range(0, 3) == 0);
      lv  = $urandom_range(0, 31);
      model(rst, ent, sal, ld, lv, clr);
      drive(rst, ent, sal, ld, lv, clr);
      check_all($sformatf("rnd%0d", i), m_occ, m_cam, m_ovf, m_unf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
